// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain front end: serializes host words onto ccff_head and holds pads isolated until load + settle.
// Optional readback CRC over ccff_tail is built only when CCFF_READBACK_EN is defined.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32,
  parameter int SETTLE    = 4
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              ccff_tail,
  output logic              ccff_head,
  output logic              chain_clk_en,
  output logic              isol_n,
  output logic              busy,
  output logic              done,
  output logic [15:0]       readback_crc
);

  // state       | meaning
  // IDLE        | no load; pads keep their last isolation setting
  // WAIT_WORD   | cfg_ready high, waiting for the next bitstream word
  // SHIFT       | one bit per cycle onto ccff_head with chain clock enabled
  // SETTLE_WAIT | whole chain loaded, counting SETTLE cycles before releasing pads

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int REM    = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int WC_W   = $clog2(NWORDS + 1);
  localparam int BC_W   = $clog2(WORD_W + 1);
  localparam int SC_W   = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_WORD   = 2'd1,
    SHIFT       = 2'd2,
    SETTLE_WAIT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic              isol_q, isol_d;
  logic              done_q, done_d;
  logic              ready_c;
  logic              shift_c;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      settle_cnt_q <= '0;
      isol_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      isol_q       <= isol_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    settle_cnt_d = settle_cnt_q;
    isol_d       = isol_q;
    done_d       = 1'b0;
    ready_c      = 1'b0;
    shift_c      = 1'b0;

    // Abort wins over any handshake or final shift in the same cycle.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      isol_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = WAIT_WORD;
            word_cnt_d = '0;
            bit_cnt_d  = '0;
            isol_d     = 1'b0;
          end
        end
        WAIT_WORD: begin
          ready_c = 1'b1;
          if (cfg_valid) begin
            shreg_d    = cfg_data;
            bit_cnt_d  = (word_cnt_q == WC_W'(NWORDS - 1)) ? BC_W'(REM) : BC_W'(WORD_W);
            word_cnt_d = word_cnt_q + WC_W'(1);
            state_d    = SHIFT;
          end
        end
        SHIFT: begin
          shift_c   = 1'b1;
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - BC_W'(1);
          if (bit_cnt_q == BC_W'(1)) begin
            if (word_cnt_q == WC_W'(NWORDS)) begin
              state_d      = SETTLE_WAIT;
              settle_cnt_d = SC_W'(SETTLE);
            end else begin
              state_d = WAIT_WORD;
            end
          end
        end
        SETTLE_WAIT: begin
          settle_cnt_d = settle_cnt_q - SC_W'(1);
          if (settle_cnt_q == SC_W'(1)) begin
            state_d = IDLE;
            isol_d  = 1'b1;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cfg_ready    = ready_c;
  assign chain_clk_en = shift_c;
  assign ccff_head    = (state_q == SHIFT) & shreg_q[WORD_W-1];
  assign isol_n       = isol_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

`ifdef CCFF_READBACK_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_fb;

  // CRC-16-CCITT, MSB-first, one ccff_tail bit per enabled chain clock.
  always_comb begin
    crc_d  = crc_q;
    crc_fb = crc_q[15] ^ ccff_tail;
    if ((state_q == IDLE) && start) begin
      crc_d = 16'hFFFF;
    end else if (shift_c) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      crc_q <= 16'hFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign readback_crc = crc_q;
`else
  logic unused_tail;
  assign unused_tail  = ccff_tail;
  assign readback_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader (CHAIN_LEN=40, WORD_W=32, SETTLE=4) with a 40-bit chain model.
module tb_ccff_bitstream_loader;
  localparam int CL = 40;
  localparam int WW = 32;
  localparam int ST = 4;
  localparam logic [31:0] W0 = 32'hA5A5A5A5;
  localparam logic [31:0] W1 = 32'hC3000000;
  localparam logic [39:0] STREAM = 40'hA5A5A5A5C3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready, ccff_head, chain_clk_en, isol_n, busy, done, ccff_tail;
  logic [15:0]   readback_crc;

  logic [CL-1:0] chain_q = '0;
  logic [63:0]   cap = '0;
  logic          isol_prev = 1'b0;
  int cyc = 0, en_cnt = 0, done_cnt = 0, last_en_cyc = 0, isol_rise_cyc = 0, done_cyc = 0;
  int total = 0, bad = 0;

  ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .SETTLE(ST)) dut (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_tail(ccff_tail), .ccff_head(ccff_head), .chain_clk_en(chain_clk_en),
    .isol_n(isol_n), .busy(busy), .done(done), .readback_crc(readback_crc)
  );

  always #5 clk = ~clk;

  // Downstream chain: shifts only on gated clocks, tail is its oldest bit.
  assign ccff_tail = chain_q[CL-1];
  always @(posedge clk) if (chain_clk_en) chain_q <= {chain_q[CL-2:0], ccff_head};

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (chain_clk_en) begin
      en_cnt++;
      cap = {cap[62:0], ccff_head};
      last_en_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (isol_n && !isol_prev) isol_rise_cyc = cyc;
    isol_prev = isol_n;
  end

  function automatic logic [15:0] crc_ref(input logic [39:0] s);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 39; i >= 0; i--) begin
      fb = c[15] ^ s[i];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

`ifdef CCFF_READBACK_EN
  localparam logic [15:0] CRC_RST = 16'hFFFF;
  wire logic [15:0] crc_exp = crc_ref(STREAM);
`else
  localparam logic [15:0] CRC_RST = 16'h0000;
  wire logic [15:0] crc_exp = 16'h0000;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, cfg_ready, 0);
    chk({tag, "_head"}, ccff_head, 0);
    chk({tag, "_en"}, chain_clk_en, 0);
    chk({tag, "_isol"}, isol_n, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_crc"}, readback_crc, CRC_RST);
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int gap);
    int n, rdy, e0;
    if (gap > 0) begin
      n = 0;
      while (!cfg_ready && n < 200) begin step(); n++; end
      chk("gap_wait_timeout", n >= 200, 0);
      rdy = 0;
      e0 = en_cnt;
      for (int i = 0; i < gap; i++) begin
        if (cfg_ready) rdy++;
        step();
      end
      chk("gap_ready_high", rdy, gap);
      chk("gap_no_enable", en_cnt - e0, 0);
    end
    cfg_data = w;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 200) begin step(); n++; end
    chk("handshake_timeout", n >= 200, 0);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input int gap, input bit spur);
    int n, e0, d0, t0;
    e0 = en_cnt;
    d0 = done_cnt;
    t0 = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_start_isol_low"}, isol_n, 0);
    chk({tag, "_start_busy"}, busy, 1);
    send_word(W0, 0);
    if (spur) begin
      repeat (5) step();
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_spur_busy"}, busy, 1);
    end
    send_word(W1, gap);
    n = 0;
    while (done_cnt == d0 && n < 100) begin step(); n++; end
    chk({tag, "_done_timeout"}, n >= 100, 0);
    repeat (3) step();
    chk({tag, "_en_count"}, en_cnt - e0, CL);
    chk({tag, "_bits"}, cap[39:0], STREAM);
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_isol_high"}, isol_n, 1);
    chk({tag, "_idle"}, busy, 0);
    // isol_n rises with SETTLE whole cycles between the last bit and the release.
    chk({tag, "_settle"}, isol_rise_cyc - last_en_cyc, ST + 1);
    chk({tag, "_done_at_release"}, done_cyc, isol_rise_cyc);
    if (gap == 0 && !spur) chk({tag, "_min_time"}, isol_rise_cyc - t0, CL + 2 + ST + 1);
  endtask

  initial begin
    int e0, d0;
    #23;
    check_reset_outputs("rst");
    step();
    rst_n = 1'b1;
    step();

    do_load("plain", 0, 1'b0);

    do_load("gap", 10, 1'b0);
    chk("gap_crc", readback_crc, crc_exp);

    do_load("spur", 0, 1'b1);
    chk("spur_crc", readback_crc, crc_exp);

    // Abort during bit index 20 of the first word.
    e0 = en_cnt;
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    send_word(W0, 0);
    repeat (20) step();
    abort = 1'b1;
    #1;
    chk("abort_en_drop", chain_clk_en, 0);
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_en", chain_clk_en, 0);
    chk("abort_isol", isol_n, 0);
    repeat (10) step();
    chk("abort_en_count", en_cnt - e0, 20);
    chk("abort_bits", cap[19:0], 20'hA5A5A);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_isol_after", isol_n, 0);

    // Asynchronous reset in the middle of SHIFT.
    start = 1'b1;
    step();
    start = 1'b0;
    send_word(W0, 0);
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    rst_n = 1'b1;
    step();
    do_load("after_rst", 0, 1'b0);

    do_load("reload", 0, 1'b0);
    chk("reload_crc", readback_crc, crc_exp);
    repeat (5) step();
    chk("crc_hold", readback_crc, crc_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
